// File: rtl/sync_fifo.sv
// Single-clock 16x8 FIFO with registered read data, full/empty flags and
// occupancy outputs. Define SYNC_FIFO_ERR_EN to add overflow/underflow pulses.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  fifo_clk,
  input  logic                  rst,
  input  logic                  fifo_wren,
  input  logic [DATA_WIDTH-1:0] fifo_wrdata,
  input  logic                  fifo_rden,
  output logic [DATA_WIDTH-1:0] fifo_rddata,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [ADDR_WIDTH:0]   fifo_room_avail,
  output logic [ADDR_WIDTH:0]   fifo_data_avail
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rddata_q, rddata_d;
  logic                  wr_acc, rd_acc;

  // Flags come straight from the registered count, so no input reaches an output.
  assign fifo_full       = (count_q == DEPTH_CNT);
  assign fifo_empty      = (count_q == '0);
  assign fifo_data_avail = count_q;
  assign fifo_room_avail = DEPTH_CNT - count_q;
  assign fifo_rddata     = rddata_q;

  always_comb begin
    wr_acc   = fifo_wren && !fifo_full;
    rd_acc   = fifo_rden && !fifo_empty;
    wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    rddata_d = rd_acc ? mem_q[rd_ptr_q] : rddata_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge fifo_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rddata_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rddata_q <= rddata_d;
    end
  end

  // Storage is not reset; reset only blocks the write on its edge.
  always_ff @(posedge fifo_clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= fifo_wrdata;
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = fifo_wren && fifo_full;
    underflow_d = fifo_rden && fifo_empty;
  end

  always_ff @(posedge fifo_clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo_overflow  = overflow_q;
  assign fifo_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: stimulus pushes expected read data into a
// scoreboard queue, a monitor pops and compares on every accepted read.
module tb_sync_fifo;

  logic       fifo_clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_wren = 1'b0;
  logic [7:0] fifo_wrdata = 8'h00;
  logic       fifo_rden = 1'b0;
  logic [7:0] fifo_rddata;
  logic       fifo_full, fifo_empty;
  logic [4:0] fifo_room_avail, fifo_data_avail;
`ifdef SYNC_FIFO_ERR_EN
  logic       fifo_overflow, fifo_underflow;
`endif

  sync_fifo dut (
    .fifo_clk        (fifo_clk),
    .rst             (rst),
    .fifo_wren       (fifo_wren),
    .fifo_wrdata     (fifo_wrdata),
    .fifo_rden       (fifo_rden),
    .fifo_rddata     (fifo_rddata),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .fifo_room_avail (fifo_room_avail),
    .fifo_data_avail (fifo_data_avail)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .fifo_overflow   (fifo_overflow),
    .fifo_underflow  (fifo_underflow)
`endif
  );

  always #5 fifo_clk = ~fifo_clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];   // scoreboard: expected rddata per accepted read
  logic [7:0] model_q[$]; // model of FIFO contents
  logic [7:0] last_rd = 8'h00;
  logic       exp_ovf = 1'b0, exp_unf = 1'b0;
  logic       mon_fire;
  logic [7:0] mon_exp;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: an accepted read is what the DUT handshake shows just before the edge.
  always @(posedge fifo_clk) begin
    mon_fire = !rst && fifo_rden && !fifo_empty;
    if (mon_fire) begin
      @(negedge fifo_clk);
      if (exp_q.size() == 0) begin
        chk("unexpected_read", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rddata_order", int'(fifo_rddata), int'(mon_exp));
      end
    end
  end

  task automatic check_state();
    int cnt;
    cnt = model_q.size();
    chk("data_avail", int'(fifo_data_avail), cnt);
    chk("room_avail", int'(fifo_room_avail), 16 - cnt);
    chk("full", int'(fifo_full), int'(cnt == 16));
    chk("empty", int'(fifo_empty), int'(cnt == 0));
    chk("rddata_hold", int'(fifo_rddata), int'(last_rd));
`ifdef SYNC_FIFO_ERR_EN
    chk("overflow", int'(fifo_overflow), int'(exp_ovf));
    chk("underflow", int'(fifo_underflow), int'(exp_unf));
`endif
  endtask

  // One clock: drive at negedge, update model, check after the edge.
  task automatic step(input logic wr, input logic [7:0] wd, input logic rd);
    logic wacc, racc;
    int cnt;
    fifo_wren   = wr;
    fifo_wrdata = wd;
    fifo_rden   = rd;
    cnt  = model_q.size();
    wacc = wr && (cnt != 16);
    racc = rd && (cnt != 0);
    exp_ovf = wr && (cnt == 16);
    exp_unf = rd && (cnt == 0);
    if (racc) begin
      last_rd = model_q.pop_front();
      exp_q.push_back(last_rd);
    end
    if (wacc) model_q.push_back(wd);
    @(posedge fifo_clk);
    @(negedge fifo_clk);
    fifo_wren = 1'b0;
    fifo_rden = 1'b0;
    check_state();
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    fifo_wren = 1'b1;   // reset must override both requests
    fifo_rden = 1'b1;
    fifo_wrdata = 8'hEE;
    repeat (n) @(posedge fifo_clk);
    @(negedge fifo_clk);
    rst       = 1'b0;
    fifo_wren = 1'b0;
    fifo_rden = 1'b0;
    model_q.delete();
    last_rd = 8'h00;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    check_state();
  endtask

  initial begin
    @(negedge fifo_clk);
    do_reset(10);

    // Fill from empty: 0x00..0x0F
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    // Write while full is dropped
    step(1'b1, 8'hFD, 1'b0);
    // Drain all 16 in order
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    // Read while empty is ignored
    step(1'b0, 8'h00, 1'b1);

    // Simultaneous traffic at mid occupancy; pointers wrap past 15
    for (int i = 0; i < 8; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 8'hFD, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b1, 8'h40 + 8'(i), 1'b1);

    // Simultaneous read+write when full: only the read is accepted
    for (int i = 0; i < 8; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
    step(1'b1, 8'hAB, 1'b1);
    step(1'b1, 8'hAC, 1'b0);
    // Drain, then simultaneous read+write when empty: only the write
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Reset with 8 entries stored, then a read must be ignored
    for (int i = 0; i < 8; i++) step(1'b1, 8'h80 + 8'(i), 1'b0);
    do_reset(1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    repeat (2) @(negedge fifo_clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
